// File: rtl/uart_instr_loader.sv
// UART program loader: receives bytes on i_rx, pairs them high-then-low into 16-bit
// words and writes them to sequential instruction addresses. Define UART_LOADER_PARITY_EN for even parity.
module uart_instr_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int IDLE_CLKS    = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_transmit_done,
    output logic [7:0]  o_max_addr,
    output logic        o_err,
    output logic [2:0]  o_rx_state
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(IDLE_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CLKS);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_LOADER_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } rx_state_t;

    rx_state_t       state, state_n;
    logic            rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            par_bad;
    logic            have_hi;
    logic [7:0]      hi_byte;
    logic [8:0]      word_cnt;
    logic [IW-1:0]   idle_cnt;
    logic            start_edge;
    logic            tick;
    logic            byte_ok;
    logic            frame_err;

    assign start_edge = rx_prev & ~rx_sync;
    assign o_rx_state = state;

    // Synchronizer resets to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        tick      = 1'b0;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_edge && !o_transmit_done) state_n = S_START;
            end
            S_START: begin
                if (clk_cnt == HALF_LAST) begin
                    tick    = 1'b1;
                    state_n = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    tick = 1'b1;
`ifdef UART_LOADER_PARITY_EN
                    if (bit_idx == 3'd7) state_n = S_PARITY;
`else
                    if (bit_idx == 3'd7) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_LOADER_PARITY_EN
            S_PARITY: begin
                if (clk_cnt == BIT_LAST) begin
                    tick    = 1'b1;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    tick    = 1'b1;
                    state_n = S_IDLE;
                    if (rx_sync && !par_bad) byte_ok   = 1'b1;
                    else                     frame_err = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bit timer restarts at every sample point, so DATA samples land one bit apart from mid-start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (tick || state == S_IDLE) clk_cnt <= '0;
            else                         clk_cnt <= clk_cnt + 1'b1;
            if (state == S_DATA && tick) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {rx_sync, shift_reg[7:1]};
            end
        end
    end

`ifdef UART_LOADER_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            par_bad <= 1'b0;
        end else if (state == S_START) begin
            par_bad <= 1'b0;
        end else if (state == S_PARITY && tick) begin
            par_bad <= rx_sync ^ (^shift_reg);
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_en         <= 1'b0;
            o_wr_addr       <= '0;
            o_wr_data       <= '0;
            o_transmit_done <= 1'b0;
            o_max_addr      <= '0;
            o_err           <= 1'b0;
            have_hi         <= 1'b0;
            hi_byte         <= '0;
            word_cnt        <= '0;
            idle_cnt        <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (byte_ok) begin
                if (have_hi) begin
                    o_wr_en    <= 1'b1;
                    o_wr_addr  <= word_cnt[7:0];
                    o_wr_data  <= {hi_byte, shift_reg};
                    o_max_addr <= word_cnt[7:0];
                    word_cnt   <= word_cnt + 9'd1;
                    have_hi    <= 1'b0;
                end else begin
                    hi_byte <= shift_reg;
                    have_hi <= 1'b1;
                end
            end
            if (frame_err) o_err <= 1'b1;
            // Memory is full after address 255; stop rather than wrap.
            if (o_wr_en && o_wr_addr == 8'hFF) o_transmit_done <= 1'b1;
            if (start_edge) begin
                idle_cnt <= '0;
            end else if (state == S_IDLE && idle_cnt != IDLE_MAX && !o_transmit_done) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == IDLE_LAST) begin
                    if (have_hi) begin
                        have_hi <= 1'b0;
                        o_err   <= 1'b1;
                    end
                    if (word_cnt != 9'd0) o_transmit_done <= 1'b1;
                end
            end
        end
    end

endmodule
